// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and FSM encoding for the instruction-memory responder
package imem_pkg;
    localparam int IMEM_WORD_W = 64;
    localparam logic [IMEM_WORD_W-1:0] IMEM_NOP = 64'h0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: single-clock word array, one write port, registered read port with write-first bypass
module imem_array import imem_pkg::*; #(
    parameter int AW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [IMEM_WORD_W-1:0] wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic [IMEM_WORD_W-1:0] rdata
);
    logic [IMEM_WORD_W-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-port memory responder with configurable wait states and side-band load port
module imem_responder import imem_pkg::*; #(
    parameter int AW = 10,
    parameter int WAIT_STATES = 2,
    parameter logic [IMEM_WORD_W-1:0] OOR_DATA = IMEM_NOP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            imem_addr,
    input  logic                   imem_addr_valid,
    output logic [IMEM_WORD_W-1:0] imem_data,
    output logic                   imem_data_valid,
    input  logic                   prog_we,
    input  logic [AW-1:0]          prog_addr,
    input  logic [IMEM_WORD_W-1:0] prog_data,
    output logic                   oor_err,
    output logic [31:0]            fetch_count
);
    imem_state_t state;
    logic [63:0] lat_addr;
    logic [3:0] cnt;
    logic rd_oor, same, relatch, fire, src_oor;
    logic [63:3] src;
    logic [IMEM_WORD_W-1:0] rdata;
    always_comb begin
        same = imem_addr == lat_addr;
        relatch = imem_addr_valid && (state == IDLE || (state == RESP && !same));
        // with zero wait states the read is issued on the same edge the address is captured
        fire = (state == WAIT && cnt == 0) || (WAIT_STATES == 0 && relatch);
        src = state == WAIT ? lat_addr[63:3] : imem_addr[63:3];
        src_oor = |src[63:AW+3];
        imem_data_valid = state == RESP && imem_addr_valid && same;
        imem_data = rd_oor ? OOR_DATA : rdata;
    end
    imem_array #(.AW(AW)) u_array (
        .clk(clk), .rst(rst),
        .we(prog_we), .waddr(prog_addr), .wdata(prog_data),
        .re(fire), .raddr(src[AW+2:3]), .rdata(rdata)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            lat_addr <= '0;
            cnt <= '0;
            rd_oor <= 1'b0;
            oor_err <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (fire) begin
                fetch_count <= fetch_count + 32'd1;
                rd_oor <= src_oor;
                if (src_oor) oor_err <= 1'b1;
            end
            if (state == WAIT) begin
                if (cnt != 0) cnt <= cnt - 4'd1;
                else state <= RESP;
            end else if (relatch) begin
                lat_addr <= imem_addr;
                cnt <= 4'(WAIT_STATES);
                state <= WAIT_STATES == 0 ? RESP : WAIT;
            end else if (state == RESP && !imem_addr_valid) state <= IDLE;
        end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and randomized checks of imem_responder against a word-array reference model
module tb_imem_responder;
    localparam int AW = 10;
    localparam int WS = 2;
    logic clk = 0, rst = 1;
    logic [63:0] addr = 0, a0 = 0;
    logic av = 0, av0 = 0;
    logic [63:0] data, d0;
    logic dv, dv0, oe, oe0;
    logic [31:0] fc, fc0;
    logic pwe = 0;
    logic [AW-1:0] pa = 0;
    logic [63:0] pd = 0;
    int tests = 0, fails = 0;
    logic [63:0] mem_m [2**AW];
    int exp_count = 0;
    logic exp_oor = 0;
    always #5 clk = ~clk;
    imem_responder #(.AW(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .imem_addr(addr), .imem_addr_valid(av),
        .imem_data(data), .imem_data_valid(dv), .prog_we(pwe), .prog_addr(pa),
        .prog_data(pd), .oor_err(oe), .fetch_count(fc)
    );
    imem_responder #(.AW(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .imem_addr(a0), .imem_addr_valid(av0),
        .imem_data(d0), .imem_data_valid(dv0), .prog_we(pwe), .prog_addr(pa),
        .prog_data(pd), .oor_err(oe0), .fetch_count(fc0)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] exp_word(input logic [63:0] a);
        return (a[63:AW+3] != 0) ? 64'h0 : mem_m[a[AW+2:3]];
    endfunction
    task automatic prog(input int idx, input logic [63:0] w);
        pwe = 1; pa = AW'(idx); pd = w;
        step();
        pwe = 0;
        mem_m[idx] = w;
    endtask
    task automatic fetch(input logic [63:0] a, input string tag);
        int k;
        logic changed;
        changed = (a !== addr) || !av;
        addr = a; av = 1;
        #1;
        if (changed) chk({tag, "_drop"}, 64'(dv), 64'd0);
        k = 0;
        do begin
            step();
            k++;
        end while (!dv && k < 50);
        if (a[63:AW+3] != 0) exp_oor = 1;
        exp_count++;
        chk({tag, "_lat"}, 64'(k), 64'(WS + 2));
        chk({tag, "_data"}, data, exp_word(a));
        chk({tag, "_count"}, 64'(fc), 64'(exp_count));
        chk({tag, "_oor"}, 64'(oe), 64'(exp_oor));
    endtask
    initial begin
        int k;
        logic [63:0] a;
        repeat (3) step();
        chk("rst_data", data, 64'h0);
        chk("rst_valid", 64'(dv), 64'd0);
        chk("rst_count", 64'(fc), 64'd0);
        chk("rst_oor", 64'(oe), 64'd0);
        rst = 0;
        step();
        prog(0, 64'hDEAD_BEEF_0000_0001);
        fetch(64'h0, "first");
        repeat (3) begin
            step();
            chk("hold_valid", 64'(dv), 64'd1);
        end
        a0 = 64'h4; av0 = 1;
        step();
        chk("ws0_valid", 64'(dv0), 64'd1);
        chk("ws0_data", d0, 64'hDEAD_BEEF_0000_0001);
        chk("ws0_count", 64'(fc0), 64'd1);
        av0 = 0;
        prog(1, 64'h1111_2222_3333_4444);
        prog(2, 64'h5555_6666_7777_8888);
        prog(3, 64'h0BAD_F00D_CAFE_0003);
        av = 0;
        step();
        fetch(64'd0, "seq0");
        fetch(64'd8, "seq8");
        fetch(64'd16, "seq16");
        fetch(64'h1_0000_0000, "oor");
        fetch(64'd24, "after_oor");
        prog(5, 64'hFFFF_0000_FFFF_0000);
        addr = 64'd40; av = 1;
        repeat (3) step();
        pwe = 1; pa = AW'(5); pd = 64'h1234;
        step();
        pwe = 0;
        mem_m[5] = 64'h1234;
        exp_count++;
        chk("bypass_valid", 64'(dv), 64'd1);
        chk("bypass_data", data, 64'h1234);
        addr = 64'd16;
        repeat (2) step();
        rst = 1;
        #1;
        chk("midrst_valid", 64'(dv), 64'd0);
        chk("midrst_count", 64'(fc), 64'd0);
        av = 0;
        step();
        rst = 0;
        exp_count = 0;
        exp_oor = 0;
        step();
        chk("postrst_valid", 64'(dv), 64'd0);
        chk("postrst_oor", 64'(oe), 64'd0);
        fetch(64'd8, "postrst");
        for (int i = 0; i < 32; i++) prog(i, {$urandom, $urandom});
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) prog($urandom_range(0, 31), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                av = 0;
                step();
            end
            a = ($urandom_range(0, 7) == 0) ? {32'($urandom_range(1, 255)), 32'($urandom)}
                                             : 64'({$urandom_range(0, 31), 3'($urandom)});
            if (a == addr) a = a ^ 64'd8;
            fetch(a, "rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
